// File: rtl/isqrt_arb_pkg.sv
// Shared types and helpers for the isqrt round-robin arbiter.
package isqrt_arb_pkg;

  localparam int unsigned ARG_W     = 32;
  localparam int unsigned RES_W     = 16;
  // Upper bound on requesters; rr_pick works on vectors of this width.
  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned MAX_REQ_W = 3;

  typedef struct packed {
    logic                 found;
    logic [MAX_REQ_W-1:0] idx;
  } rr_pick_t;

  // First set bit of vld at or above ptr, wrapping modulo n (n <= MAX_REQ).
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   vld,
                                       input logic [MAX_REQ_W-1:0] ptr,
                                       input int unsigned          n);
    rr_pick_t             res;
    logic [MAX_REQ_W-1:0] cand;
    res = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      cand = MAX_REQ_W'((32'(ptr) + k) % n);
      if (k < n && !res.found && vld[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/isqrt_arb_id_fifo.sv
// Owner-ID FIFO: records which requester issued each in-flight isqrt argument.
module isqrt_arb_id_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [Width-1:0]               push_data,
  input  logic                           pop,
  output logic [Width-1:0]               pop_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(Depth+1)-1:0]     count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full     = (count_q == CntW'(Depth));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign pop_ok   = pop & ~empty;
  // A push into a full FIFO is accepted only when a pop frees the slot this cycle.
  assign push_ok  = push & (~full | pop_ok);

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = push_ok ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CntW'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/isqrt_rr_arbiter.sv
// Round-robin sharing of one fixed-latency, in-order isqrt core among N_REQ requesters.
module isqrt_rr_arbiter
  import isqrt_arb_pkg::*;
#(
  parameter int unsigned N_REQ        = 2,
  parameter int unsigned MAX_INFLIGHT = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_REQ-1:0]                  req_x_vld,
  input  logic [N_REQ*ARG_W-1:0]            req_x,
  output logic [N_REQ-1:0]                  req_x_rdy,
  output logic [N_REQ-1:0]                  req_y_vld,
  output logic [RES_W-1:0]                  req_y,
  output logic                              isqrt_x_vld,
  output logic [ARG_W-1:0]                  isqrt_x,
  input  logic                              isqrt_y_vld,
  input  logic [RES_W-1:0]                  isqrt_y,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              err_underflow
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  rr_pick_t         pick;
  logic             fifo_full, fifo_empty;
  logic             can_issue, grant, pop;
  logic [ID_W-1:0]  gnt_idx, head_id;
  logic [N_REQ-1:0] req_y_vld_d, req_y_vld_q;
  logic [RES_W-1:0] req_y_q;
  logic             err_q;

  assign pick      = rr_pick(MAX_REQ'(req_x_vld), MAX_REQ_W'(rr_ptr_q), N_REQ);
  assign pop       = isqrt_y_vld & ~fifo_empty;
  // A returning result frees a FIFO slot in the same cycle, so a full FIFO can still issue.
  assign can_issue = ~fifo_full | isqrt_y_vld;
  // Grants are suppressed while reset is asserted, independent of register state.
  assign grant     = ~rst & can_issue & pick.found;

  // Decode the picked index into a one-hot grant and mux the granted argument.
  always_comb begin
    gnt_idx   = '0;
    req_x_rdy = '0;
    isqrt_x   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant && pick.idx == MAX_REQ_W'(i)) begin
        gnt_idx      = ID_W'(i);
        req_x_rdy[i] = 1'b1;
        isqrt_x      = req_x[i*ARG_W +: ARG_W];
      end
    end
  end

  assign isqrt_x_vld = |req_x_rdy;

  // Round-robin pointer moves just past the winner; holds without a grant.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  isqrt_arb_id_fifo #(
    .Depth (MAX_INFLIGHT),
    .Width (ID_W)
  ) u_id_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant),
    .push_data (gnt_idx),
    .pop       (pop),
    .pop_data  (head_id),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (inflight)
  );

  // Steer a popped result to the requester recorded at the FIFO head.
  always_comb begin
    req_y_vld_d = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pop && head_id == ID_W'(i)) begin
        req_y_vld_d[i] = 1'b1;
      end
    end
  end

  // Registered return path and sticky underflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_y_vld_q <= '0;
      req_y_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      req_y_vld_q <= req_y_vld_d;
      if (pop) begin
        req_y_q <= isqrt_y;
      end
      if (isqrt_y_vld && fifo_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  assign req_y_vld     = req_y_vld_q;
  assign req_y         = req_y_q;
  assign err_underflow = err_q;

endmodule
